// File: rtl/tiny_riscv_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and serialiser states.
package tiny_riscv_uart_tx_pkg;

  localparam logic [1:0] TX_REG_DATA   = 2'd0;
  localparam logic [1:0] TX_REG_STATUS = 2'd1;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_EMPTY = 2;
  localparam int unsigned STAT_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/tiny_riscv_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; shared by UART TX and RX.
module tiny_riscv_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_N,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en, pop_en;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_data  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign push_en = i_push && (!o_full || i_pop);
  assign pop_en  = i_pop && !o_empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(push_en);
    rd_ptr_d = rd_ptr_q + AW'(pop_en);
    count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    if (push_en) begin
      mem_d[wr_ptr_q] = i_data;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tiny_riscv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/overflow logic and
// the frame serialiser draining a small TX FIFO onto o_UART_TX.
module tiny_riscv_uart_tx
  import tiny_riscv_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst_N,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic        i_write_strobe,
  input  logic        i_read_strobe,
  output logic [31:0] o_mem_data,
  output logic        o_UART_TX
);

  localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      mem_data_q, mem_data_d;

  logic        hit, wr_en, rd_en, baud_end, busy;
  logic [1:0]  offset;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_data;
  logic [31:0] status_word;
  logic        unused_bits;

  assign unused_bits = ^{i_mem_wdata[31:8], i_mem_addr[1:0]};

  assign hit       = (i_mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = i_mem_addr[3:2];
  assign wr_en     = i_write_strobe && hit;
  assign rd_en     = i_read_strobe && hit && !i_write_strobe;
  assign fifo_push = wr_en && (offset == TX_REG_DATA);
  assign busy      = (state_q != S_IDLE) || !fifo_empty;
  assign baud_end  = (baud_q == CNT_LAST);

  tiny_riscv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_N (i_Rst_N),
    .i_push  (fifo_push),
    .i_data  (i_mem_wdata[7:0]),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    status_word             = '0;
    status_word[STAT_BUSY]  = busy;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_OVF]   = ovf_q;
  end

  // The STATUS read captures ovf on the edge that clears it; a write never coincides with it.
  always_comb begin
    mem_data_d = '0;
    ovf_d      = ovf_q;
    if (rd_en && (offset == TX_REG_STATUS)) begin
      mem_data_d = status_word;
      ovf_d      = 1'b0;
    end
    if (fifo_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      baud_d = '0;
    end
  end

  // Line level is derived from the next state so the pin is a plain flop output.
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign o_mem_data = mem_data_q;
  assign o_UART_TX  = tx_q;

endmodule

// File: tb/tb_tiny_riscv_uart_tx.sv
// Directed-plus-random bench for tiny_riscv_uart_tx: a transaction-level model of
// the FIFO/serialiser timing predicts STATUS reads and the byte stream on the line.
module tb_tiny_riscv_uart_tx;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] STAT  = 32'h0001_0004;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wstb = 1'b0;
  logic        rstb = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_data;
  logic        tx;

  tiny_riscv_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_N        (rst_n),
    .i_mem_addr     (addr),
    .i_mem_wdata    (wdata),
    .i_write_strobe (wstb),
    .i_read_strobe  (rstb),
    .o_mem_data     (mem_data),
    .o_UART_TX      (tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: pending bytes, bytes handed to the line, and when the frame in flight ends.
  byte unsigned mq[$];
  byte unsigned sent[$];
  bit           m_idle = 1'b1;
  int           m_frame_end = 0;
  bit           m_ovf = 1'b0;
  logic [31:0]  m_rdata = '0;

  // Line monitor output.
  byte unsigned rx[$];
  int           rx_start[$];
  bit           rx_stop[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int t);
    bit hit, rd, push_req, empty, full, busy, pop;
    if (!rst_n) begin
      mq.delete();
      m_idle  = 1'b1;
      m_ovf   = 1'b0;
      m_rdata = '0;
      return;
    end
    hit      = (addr[31:4] == BASE[31:4]);
    rd       = rstb && hit && !wstb;
    push_req = wstb && hit && (addr[3:2] == 2'd0);
    empty    = (mq.size() == 0);
    full     = (mq.size() == DEPTH);
    busy     = !m_idle || !empty;
    pop      = !empty && (m_idle || t == m_frame_end);
    if (!m_idle && t == m_frame_end && !pop) m_idle = 1'b1;
    m_rdata = '0;
    if (rd && addr[3:2] == 2'd1) begin
      m_rdata = {28'b0, m_ovf, empty, full, busy};
      m_ovf   = 1'b0;
    end
    if (push_req && full && !pop) m_ovf = 1'b1;
    if (pop) begin
      sent.push_back(mq.pop_front());
      m_idle      = 1'b0;
      m_frame_end = t + FRAME;
    end
    if (push_req && (!full || pop)) mq.push_back(wdata[7:0]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_edge(cyc);
    end
  end

  // Decode 8N1 frames by sampling each bit at its centre.
  initial begin
    int           st;
    byte unsigned b;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        st = cyc;
        b  = 8'h00;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = (tx === 1'b1);
        end
        repeat (CPB) @(negedge clk);
        rx_stop.push_back(tx === 1'b1);
        rx.push_back(b);
        rx_start.push_back(st);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: cycle=%0d limit=%0d", cyc, 50000);
    $fatal(1);
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wstb  = 1'b1;
    @(negedge clk);
    wstb  = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    rstb = 1'b1;
    @(negedge clk);
    rstb = 1'b0;
    d    = mem_data;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_frames(input string tag, input int exp_n);
    int budget = 0;
    while ((rx.size() < sent.size() || !m_idle || mq.size() != 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    chk({tag, "_model_n"}, sent.size(), exp_n);
    chk({tag, "_line_n"}, rx.size(), exp_n);
    for (int i = 0; i < rx.size() && i < sent.size(); i++) begin
      chk({tag, "_byte"}, rx[i], sent[i]);
      chk({tag, "_stop"}, rx_stop[i], 1);
    end
    rx.delete();
    rx_stop.delete();
    rx_start.delete();
    sent.delete();
  endtask

  initial begin
    logic [31:0]  d;
    int           e;
    int           fall;
    byte unsigned b;

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_rdata", mem_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(STAT, d);
    chk("rst_status", d, 32'h4);

    // 1. Single byte: latency, exact frame length
    do_write(BASE, 32'hA5);
    chk("t1_tx_after_push", tx, 1);
    @(negedge clk);
    chk("t1_tx_start", tx, 0);
    e = cyc;
    wait_until(e + FRAME - 1);
    chk("t1_stop_level", tx, 1);
    do_read(STAT, d);
    chk("t1_status_last", d, 32'h5);
    do_read(STAT, d);
    chk("t1_status_done", d, 32'h4);
    chk("t1_idle_tx", tx, 1);
    chk("t1_first_byte", (rx.size() > 0) ? rx[0] : 8'h00, 8'hA5);
    check_frames("t1", 1);

    // 2. Back-to-back frames, busy held until the second stop bit ends
    do_write(BASE, 32'h55);
    e = cyc + 1;
    do_write(BASE, 32'h0F);
    fall = -1;
    for (int i = 0; i < 90; i++) begin
      do_read(STAT, d);
      chk("t2_status", d, m_rdata);
      if (d[0] === 1'b0 && fall < 0) fall = cyc;
    end
    chk("t2_busy_fall", fall, e + 2 * FRAME + 1);
    chk("t2_frames_seen", rx_start.size(), 2);
    if (rx_start.size() >= 2) chk("t2_gap", rx_start[1] - rx_start[0], FRAME);
    check_frames("t2", 2);

    // 3. Overflow: six consecutive random writes
    for (int i = 0; i < 6; i++) do_write(BASE, $urandom_range(0, 255));
    do_read(STAT, d);
    chk("t3_status_ovf", d, 32'hB);
    do_read(STAT, d);
    chk("t3_status_clr", d, 32'h3);
    check_frames("t3", 5);

    // 6. Read+write to TXDATA on the pop edge with the FIFO full
    for (int i = 0; i < 5; i++) do_write(BASE, $urandom_range(0, 255));
    wait_until(m_frame_end - 1);
    addr  = BASE;
    wdata = $urandom_range(0, 255);
    wstb  = 1'b1;
    rstb  = 1'b1;
    @(negedge clk);
    wstb  = 1'b0;
    rstb  = 1'b0;
    chk("t6_rdata_zero", mem_data, 0);
    do_read(STAT, d);
    chk("t6_status_full", d, 32'h3);
    check_frames("t6", 6);

    // 4. Reset during data bit 3 of a frame with bytes queued and ovf set
    b = 8'($urandom_range(0, 255)) & 8'hF7;
    do_write(BASE, {24'h0, b});
    e = cyc + 1;
    for (int i = 0; i < 5; i++) do_write(BASE, $urandom_range(0, 255));
    wait_until(e + 4 * CPB);
    chk("t4_bit3_low", tx, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_tx_in_reset", tx, 1);
    rst_n = 1'b1;
    do_read(STAT, d);
    chk("t4_status_after", d, 32'h4);
    repeat (60) @(negedge clk);
    rx.delete();
    rx_stop.delete();
    rx_start.delete();
    sent.delete();
    repeat (150) @(negedge clk);
    chk("t4_no_frames", rx.size(), 0);
    chk("t4_tx_idle", tx, 1);

    // 5. Decode and read-data gating
    do_read(STAT, d);
    chk("t5_status", d, 32'h4);
    do_read(32'h0001_0008, d);
    chk("t5_reserved_rd", d, 0);
    do_read(32'h0002_0004, d);
    chk("t5_miss_rd", d, 0);
    do_read(BASE, d);
    chk("t5_txdata_rd", d, 0);
    do_read(32'h0001_000C, d);
    chk("t5_reserved3_rd", d, m_rdata);
    do_write(32'h0002_0000, 32'h3C);
    do_write(32'h0001_0008, 32'hC3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_idle_rdata", mem_data, 0);
    end
    repeat (60) @(negedge clk);
    chk("t5_no_frame", rx.size(), 0);
    chk("t5_model_empty", sent.size(), 0);
    do_read(STAT, d);
    chk("t5_status_end", d, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
